// File: rtl/reg_wb_if.sv
// Writeback-stage bus: exe/mem result inputs, register-file write port and pending mask.
// Optional forwarding lookup ports exist only when WB_BYPASS_EN is defined.
interface reg_wb_if;
    logic        exe_valid;
    logic [3:0]  exe_idx;
    logic [31:0] exe_data;
    logic        exe_ready;
    logic        mem_valid;
    logic [3:0]  mem_idx;
    logic [31:0] mem_data;
    logic        reg_write;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic [15:0] pend_mask;
`ifdef WB_BYPASS_EN
    logic [3:0]  fwd_idx1;
    logic [3:0]  fwd_idx2;
    logic [3:0]  fwd_idx3;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic        fwd_hit3;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [31:0] fwd_data3;
`endif

    modport master (
        output exe_valid, exe_idx, exe_data, mem_valid, mem_idx, mem_data,
        input  exe_ready, reg_write, wr_idx, wr_data, pend_mask
`ifdef WB_BYPASS_EN
        ,
        output fwd_idx1, fwd_idx2, fwd_idx3,
        input  fwd_hit1, fwd_hit2, fwd_hit3, fwd_data1, fwd_data2, fwd_data3
`endif
    );

    modport slave (
        input  exe_valid, exe_idx, exe_data, mem_valid, mem_idx, mem_data,
        output exe_ready, reg_write, wr_idx, wr_data, pend_mask
`ifdef WB_BYPASS_EN
        ,
        input  fwd_idx1, fwd_idx2, fwd_idx3,
        output fwd_hit1, fwd_hit2, fwd_hit3, fwd_data1, fwd_data2, fwd_data3
`endif
    );
endinterface

// File: rtl/reg_wb_stage.sv
// Writeback stage: arbitrates mem/exe results onto the register-file write port, queueing exe.
// Define WB_BYPASS_EN to add three combinational forwarding lookups against pending writes.
module reg_wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    reg_wb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [3:0]       fifo_idx_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             reg_write_q, reg_write_d;
    logic [3:0]       wr_idx_q, wr_idx_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic exe_ready, exe_wr, mem_wr, fifo_ne, push, pop, bypass;

    // Results for r0 are accepted but never reach the FIFO or the write port.
    assign exe_ready = (count_q < CNT_W'(DEPTH));
    assign exe_wr    = bus.exe_valid && exe_ready && (bus.exe_idx != 4'd0);
    assign mem_wr    = bus.mem_valid && (bus.mem_idx != 4'd0);
    assign fifo_ne   = (count_q != '0);
    assign push      = exe_wr && (mem_wr || fifo_ne);
    assign pop       = !mem_wr && fifo_ne;
    assign bypass    = !mem_wr && !fifo_ne && exe_wr;

    always_comb begin
        reg_write_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        if (mem_wr) begin
            reg_write_d = 1'b1;
            wr_idx_d    = bus.mem_idx;
            wr_data_d   = bus.mem_data;
        end else if (pop) begin
            reg_write_d = 1'b1;
            wr_idx_d    = fifo_idx_q[rd_ptr_q];
            wr_data_d   = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            reg_write_d = 1'b1;
            wr_idx_d    = bus.exe_idx;
            wr_data_d   = bus.exe_data;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (push)
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            wr_idx_q    <= 4'd0;
            wr_data_q   <= 32'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            vld_q       <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            // Push and pop never share a slot: that needs an empty or a full FIFO.
            if (pop)
                vld_q[rd_ptr_q] <= 1'b0;
            if (push)
                vld_q[wr_ptr_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= bus.exe_idx;
            fifo_data_q[wr_ptr_q] <= bus.exe_data;
        end
    end

    logic [15:0] slot_mask [DEPTH];
    logic [15:0] pend_mask;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_mask[gi] = vld_q[gi] ? (16'h0001 << fifo_idx_q[gi]) : 16'h0000;
        end
    endgenerate

    always_comb begin
        pend_mask = reg_write_q ? (16'h0001 << wr_idx_q) : 16'h0000;
        for (int k = 0; k < DEPTH; k++)
            pend_mask = pend_mask | slot_mask[k];
    end

    assign bus.exe_ready = exe_ready;
    assign bus.reg_write = reg_write_q;
    assign bus.wr_idx    = wr_idx_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.pend_mask = pend_mask;

`ifdef WB_BYPASS_EN
    logic [3:0]  fwd_idx  [3];
    logic        fwd_hit  [3];
    logic [31:0] fwd_data [3];

    assign fwd_idx[0] = bus.fwd_idx1;
    assign fwd_idx[1] = bus.fwd_idx2;
    assign fwd_idx[2] = bus.fwd_idx3;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] slot;

            // Scan oldest to youngest so the tail-most FIFO match overrides the write register.
            always_comb begin
                fwd_hit[gi]  = 1'b0;
                fwd_data[gi] = 32'd0;
                sum          = '0;
                slot         = '0;
                if (reg_write_q && (wr_idx_q == fwd_idx[gi])) begin
                    fwd_hit[gi]  = 1'b1;
                    fwd_data[gi] = wr_data_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    sum = {1'b0, rd_ptr_q} + (PTR_W+1)'(k);
                    if (sum >= (PTR_W+1)'(DEPTH))
                        sum = sum - (PTR_W+1)'(DEPTH);
                    slot = sum[PTR_W-1:0];
                    if ((CNT_W'(k) < count_q) && (fifo_idx_q[slot] == fwd_idx[gi])) begin
                        fwd_hit[gi]  = 1'b1;
                        fwd_data[gi] = fifo_data_q[slot];
                    end
                end
                if (fwd_idx[gi] == 4'd0)
                    fwd_hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.fwd_hit1  = fwd_hit[0];
    assign bus.fwd_hit2  = fwd_hit[1];
    assign bus.fwd_hit3  = fwd_hit[2];
    assign bus.fwd_data1 = fwd_data[0];
    assign bus.fwd_data2 = fwd_data[1];
    assign bus.fwd_data3 = fwd_data[2];
`endif
endmodule

// File: tb/tb_reg_wb_stage.sv
// Scoreboard bench for reg_wb_stage: a queue model predicts each cycle's write and pending mask.
// Forwarding lookups are also checked when WB_BYPASS_EN is defined.
module tb_reg_wb_stage;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [15:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    reg_wb_if bus ();

    reg_wb_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    wr_t         pend_q [$];
    exp_t        sb_q   [$];
    logic [3:0]  last_idx;
    logic [31:0] last_data;
    logic        cur_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void fwd_model(input logic [3:0] idx, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (idx == 4'd0)
            return;
        if (cur_we && last_idx == idx) begin
            hit  = 1'b1;
            data = last_data;
        end
        foreach (pend_q[k])
            if (pend_q[k].idx == idx) begin
                hit  = 1'b1;
                data = pend_q[k].data;
            end
    endfunction

    task automatic drive_idle();
        bus.exe_valid = 1'b0;
        bus.exe_idx   = 4'd0;
        bus.exe_data  = 32'd0;
        bus.mem_valid = 1'b0;
        bus.mem_idx   = 4'd0;
        bus.mem_data  = 32'd0;
`ifdef WB_BYPASS_EN
        bus.fwd_idx1  = 4'd0;
        bus.fwd_idx2  = 4'd0;
        bus.fwd_idx3  = 4'd0;
`endif
    endtask

`ifdef WB_BYPASS_EN
    task automatic chk_fwd();
        logic        h;
        logic [31:0] d;
        fwd_model(bus.fwd_idx1, h, d);
        chk("fwd_hit1", bus.fwd_hit1, h);
        if (h) chk("fwd_data1", bus.fwd_data1, d);
        fwd_model(bus.fwd_idx2, h, d);
        chk("fwd_hit2", bus.fwd_hit2, h);
        if (h) chk("fwd_data2", bus.fwd_data2, d);
        fwd_model(bus.fwd_idx3, h, d);
        chk("fwd_hit3", bus.fwd_hit3, h);
        if (h) chk("fwd_data3", bus.fwd_data3, d);
    endtask
`endif

    // One clock of stimulus; acc reports whether the exe offer was taken.
    task automatic do_cycle(input logic ev, input logic [3:0] eidx, input logic [31:0] edata,
                            input logic mv, input logic [3:0] midx, input logic [31:0] mdata,
                            output logic acc);
        exp_t e;
        exp_t got;
        wr_t  w;
        logic ready_m;
        bus.exe_valid = ev;
        bus.exe_idx   = eidx;
        bus.exe_data  = edata;
        bus.mem_valid = mv;
        bus.mem_idx   = midx;
        bus.mem_data  = mdata;
        #1;
        ready_m = (pend_q.size() < DEPTH);
        chk("exe_ready", bus.exe_ready, ready_m);
        acc  = ev && ready_m;
        e.we = 1'b0;
        e.idx  = last_idx;
        e.data = last_data;
        if (mv && midx != 4'd0) begin
            if (acc && eidx != 4'd0) pend_q.push_back('{eidx, edata});
            e.we = 1'b1; e.idx = midx; e.data = mdata;
        end else begin
            if (acc && eidx != 4'd0) pend_q.push_back('{eidx, edata});
            if (pend_q.size() != 0) begin
                w = pend_q.pop_front();
                e.we = 1'b1; e.idx = w.idx; e.data = w.data;
            end
        end
        last_idx  = e.idx;
        last_data = e.data;
        cur_we    = e.we;
        e.mask = 16'h0000;
        foreach (pend_q[k]) e.mask[pend_q[k].idx] = 1'b1;
        if (e.we) e.mask[e.idx] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        chk("reg_write", bus.reg_write, got.we);
        chk("wr_idx", bus.wr_idx, got.idx);
        chk("wr_data", bus.wr_data, got.data);
        chk("pend_mask", bus.pend_mask, got.mask);
        $display("cyc %0d: exe v=%0b i=%0d acc=%0b mem v=%0b i=%0d -> we=%0b idx=%0d data=%h mask=%h",
                 cyc, ev, eidx, acc, mv, midx, bus.reg_write, bus.wr_idx, bus.wr_data, bus.pend_mask);
`ifdef WB_BYPASS_EN
        bus.fwd_idx1 = 4'($urandom_range(0, 15));
        bus.fwd_idx2 = 4'($urandom_range(0, 15));
        bus.fwd_idx3 = last_idx;
        #1;
        chk_fwd();
`endif
    endtask

    task automatic idle_cycle();
        logic a;
        do_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, a);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend_q.size() != 0 || cur_we) && n < 20) begin
            idle_cycle();
            n++;
        end
        chk("drain_done", 32'(pend_q.size()), 32'd0);
    endtask

    // Reset held 2 cycles with an exe offer present; nothing may be captured.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        bus.exe_valid = 1'b1;
        bus.exe_idx   = 4'd5;
        bus.exe_data  = 32'h5555_5555;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pend_q.delete();
        sb_q.delete();
        last_idx  = 4'd0;
        last_data = 32'd0;
        cur_we    = 1'b0;
        chk("rst_reg_write", bus.reg_write, 1'b0);
        chk("rst_wr_idx", bus.wr_idx, 4'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_pend_mask", bus.pend_mask, 16'h0000);
        chk("rst_exe_ready", bus.exe_ready, 1'b1);
`ifdef WB_BYPASS_EN
        bus.fwd_idx1 = 4'd5;
        bus.fwd_idx2 = 4'd1;
        bus.fwd_idx3 = 4'd15;
        #1;
        chk("rst_fwd_hit1", bus.fwd_hit1, 1'b0);
        chk("rst_fwd_hit2", bus.fwd_hit2, 1'b0);
        chk("rst_fwd_hit3", bus.fwd_hit3, 1'b0);
`endif
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a;
        logic [3:0]  items [3];
        int          it;
        rst = 1'b1;
        drive_idle();
        do_reset();
        idle_cycle();

        // Single uncontended exe result
        do_cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, a);
        chk("t2_pend5_set", bus.pend_mask[5], 1'b1);
        idle_cycle();
        chk("t2_pend5_clr", bus.pend_mask[5], 1'b0);

        // mem and exe in the same cycle
        do_cycle(1'b1, 4'd4, 32'h22, 1'b1, 4'd3, 32'h11, a);
        chk("t3_mask", bus.pend_mask, 16'h0018);
        drain();

        // mem burst of 4 cycles; exe holds each item until accepted
        items[0] = 4'd1; items[1] = 4'd2; items[2] = 4'd6;
        it = 0;
        for (int c = 0; c < 20 && it < 3; c++) begin
            do_cycle(1'b1, items[it], 32'h100 + 32'(items[it]), (c < 4), 4'(8 + c), 32'hA0 + 32'(c), a);
            if (a) it++;
        end
        chk("t4_all_accepted", it, 3);
        drain();

        // r0 results from both sources
        do_cycle(1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 32'h5678, a);
        chk("t5_no_write", bus.reg_write, 1'b0);
        chk("t5_mask", bus.pend_mask, 16'h0000);
        idle_cycle();

`ifdef WB_BYPASS_EN
        do_cycle(1'b1, 4'd7, 32'hA, 1'b1, 4'd9, 32'h99, a);
        do_cycle(1'b1, 4'd7, 32'hB, 1'b1, 4'd10, 32'h1010, a);
        bus.fwd_idx1 = 4'd7;
        bus.fwd_idx2 = 4'd0;
        bus.fwd_idx3 = 4'd10;
        #1;
        chk("t6_hit1", bus.fwd_hit1, 1'b1);
        chk("t6_data1", bus.fwd_data1, 32'hB);
        chk("t6_hit2", bus.fwd_hit2, 1'b0);
        chk("t6_hit3", bus.fwd_hit3, 1'b1);
        chk("t6_data3", bus.fwd_data3, 32'h1010);
        drain();
`endif

        // Fill the FIFO behind a mem burst, then reset mid-operation
        do_cycle(1'b1, 4'd11, 32'hB1, 1'b1, 4'd12, 32'hC1, a);
        do_cycle(1'b1, 4'd13, 32'hB2, 1'b1, 4'd14, 32'hC2, a);
        do_reset();
        idle_cycle();
        chk("midrst_no_pulse", bus.reg_write, 1'b0);

        // Random traffic, r0 included
        for (int c = 0; c < 150; c++) begin
            do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                     ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), $urandom, a);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
